// File: rtl/alu_operand_seq_pkg.sv
// Shared ALU stage definitions: sequencer state encodings, settle bounds and
// opcode constants for the ALU gate family.
package alu_operand_seq_pkg;

  // Operand sequencer states.
  typedef enum logic [1:0] {
    ST_GET_A = 2'd0,
    ST_GET_B = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

  // Legal settle interval and the width of the settle counter.
  localparam int SETTLE_MIN = 1;
  localparam int SETTLE_MAX = 15;
  localparam int SETTLE_CNT_W = 4;

  // Gate selection codes; only XOR exists today, the rest follow later.
  localparam logic [1:0] OP_XOR = 2'd0;
  localparam logic [1:0] OP_AND = 2'd1;
  localparam logic [1:0] OP_OR  = 2'd2;
  localparam logic [1:0] OP_NOT = 2'd3;

  // True when a settle value can be represented by the settle counter.
  function automatic logic settle_ok(input int settle);
    return (settle >= SETTLE_MIN) && (settle <= SETTLE_MAX);
  endfunction

endpackage

// File: rtl/alu_operand_seq.sv
// Operand sequencer in front of a combinational ALU gate. Collects A then B
// from a narrow beat bus, holds them on the gate inputs for SETTLE cycles,
// captures the gate output and offers it downstream.
//
// Handshake rules: a transfer happens on a rising edge where valid and ready
// are both high. in_ready is a pure function of state. res_valid, once
// raised, stays high with res_data unchanged until res_ready is seen.
module alu_operand_seq
  import alu_operand_seq_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] alu_y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             busy
);

  // Counter preload: WAIT lasts SETTLE cycles, the last one at count zero.
  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = SETTLE_CNT_W'(SETTLE - 1);

  seq_state_t              state, state_nxt;
  logic [WIDTH-1:0]        op_a_nxt, op_b_nxt, res_data_nxt;
  logic                    res_valid_nxt;
  logic [SETTLE_CNT_W-1:0] cnt, cnt_nxt;

  // State and datapath registers; reset discards partial operands and results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_GET_A;
      op_a      <= '0;
      op_b      <= '0;
      res_data  <= '0;
      res_valid <= 1'b0;
      cnt       <= '0;
    end else begin
      state     <= state_nxt;
      op_a      <= op_a_nxt;
      op_b      <= op_b_nxt;
      res_data  <= res_data_nxt;
      res_valid <= res_valid_nxt;
      cnt       <= cnt_nxt;
    end
  end

  // Next-state, datapath updates and state-decoded handshake outputs.
  always_comb begin
    state_nxt     = state;
    op_a_nxt      = op_a;
    op_b_nxt      = op_b;
    res_data_nxt  = res_data;
    res_valid_nxt = res_valid;
    cnt_nxt       = cnt;
    in_ready      = 1'b0;
    busy          = 1'b1;
    case (state)
      ST_GET_A: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          op_a_nxt  = in_data;
          state_nxt = ST_GET_B;
        end
      end
      ST_GET_B: begin
        in_ready = 1'b1;
        if (in_valid) begin
          op_b_nxt  = in_data;
          cnt_nxt   = SETTLE_LOAD;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt == '0) begin
          res_data_nxt  = alu_y;
          res_valid_nxt = 1'b1;
          state_nxt     = ST_DONE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ST_DONE: begin
        if (res_valid && res_ready) begin
          res_valid_nxt = 1'b0;
          state_nxt     = ST_GET_A;
        end
      end
      default: begin
        state_nxt = ST_GET_A;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_operand_seq.sv
// Bench for alu_operand_seq: one instance with SETTLE=1 and one with SETTLE=3,
// each closing the loop through a behavioural XOR gate.
module tb_alu_operand_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_data;
  logic       res_ready;

  logic       in_ready1, res_valid1, busy1;
  logic [3:0] op_a1, op_b1, alu_y1, res_data1;
  logic       in_ready3, res_valid3, busy3;
  logic [3:0] op_a3, op_b3, alu_y3, res_data3;

  logic       alu_ovr_en;
  logic [3:0] alu_ovr;

  int vectors = 0;
  int miscompares = 0;
  logic [3:0] exp_q[$];

  // Behavioural XOR gates; the SETTLE=3 gate can be overridden with junk.
  assign alu_y1 = op_a1 ^ op_b1;
  assign alu_y3 = alu_ovr_en ? alu_ovr : (op_a3 ^ op_b3);

  alu_operand_seq #(.WIDTH(4), .SETTLE(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .op_a(op_a1), .op_b(op_b1), .alu_y(alu_y1),
    .res_valid(res_valid1), .res_ready(res_ready), .res_data(res_data1),
    .busy(busy1)
  );

  alu_operand_seq #(.WIDTH(4), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3),
    .in_data(in_data), .op_a(op_a3), .op_b(op_b3), .alu_y(alu_y3),
    .res_valid(res_valid3), .res_ready(res_ready), .res_data(res_data3),
    .busy(busy3)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until the SETTLE=1 instance takes it.
  task automatic send_beat(input logic [3:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready1 && n < 50) begin
      step();
      n++;
    end
    if (!in_ready1) begin
      miscompares++;
      $display("FAIL send_beat timeout: in_ready=%b required 1", in_ready1);
    end
    step();
    in_valid = 1'b0;
  endtask

  // Wait a bounded number of cycles for a result on the SETTLE=1 instance.
  task automatic wait_res1();
    int n = 0;
    while (!res_valid1 && n < 20) begin
      step();
      n++;
    end
    vectors++;
    if (res_valid1 !== 1'b1) begin
      miscompares++;
      $display("FAIL wait_res timeout: res_valid=%b required 1", res_valid1);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++;
    if ({in_ready1, busy1, res_valid1, res_data1, op_a1, op_b1} !== {1'b1, 1'b0, 1'b0, 12'h000}) begin
      miscompares++;
      $display("FAIL reset_state: got rdy=%b busy=%b vld=%b res=%h a=%h b=%h required 1 0 0 0 0 0",
               in_ready1, busy1, res_valid1, res_data1, op_a1, op_b1);
    end
  endtask

  task automatic test_basic_xor();
    logic [3:0] a = 4'b1010;
    logic [3:0] b = 4'b0110;
    res_ready = 1'b1;
    send_beat(a);
    send_beat(b);
    vectors++;
    if ({op_a1, op_b1, res_valid1} !== {a, b, 1'b0}) begin
      miscompares++;
      $display("FAIL basic_operands: a=%b b=%b vld=%b required %b %b 0", op_a1, op_b1, res_valid1, a, b);
    end
    step();
    vectors++;
    if (res_valid1 !== 1'b1 || res_data1 !== (a ^ b)) begin
      miscompares++;
      $display("FAIL basic_result: vld=%b res=%b required 1 %b", res_valid1, res_data1, a ^ b);
    end
    step();
    vectors++;
    if (res_valid1 !== 1'b0 || in_ready1 !== 1'b1 || busy1 !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_drain: vld=%b rdy=%b busy=%b required 0 1 0", res_valid1, in_ready1, busy1);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] a = 4'($urandom_range(0, 15));
    logic [3:0] b = 4'($urandom_range(0, 15));
    res_ready = 1'b0;
    send_beat(a);
    send_beat(b);
    step();
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({res_valid1, res_data1, in_ready1, busy1, op_a1, op_b1} !== {1'b1, a ^ b, 1'b0, 1'b1, a, b}) begin
        miscompares++;
        $display("FAIL backpressure_hold[%0d]: vld=%b res=%h rdy=%b busy=%b a=%h b=%h required 1 %h 0 1 %h %h",
                 i, res_valid1, res_data1, in_ready1, busy1, op_a1, op_b1, a ^ b, a, b);
      end
      step();
    end
    res_ready = 1'b1;
    step();
    vectors++;
    if (res_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
      miscompares++;
      $display("FAIL backpressure_drain: vld=%b rdy=%b required 0 1", res_valid1, in_ready1);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] beats[4];
    int idx = 0;
    int got = 0;
    int n = 0;
    logic [3:0] e;
    beats[0] = 4'b0011; beats[1] = 4'b0101; beats[2] = 4'b1111; beats[3] = 4'b0000;
    exp_q.push_back(beats[0] ^ beats[1]);
    exp_q.push_back(beats[2] ^ beats[3]);
    res_ready = 1'b1;
    while ((idx < 4 || exp_q.size() != 0) && n < 60) begin
      in_valid = (idx < 4);
      in_data  = (idx < 4) ? beats[idx] : 4'h0;
      if (res_valid1) begin
        got++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL b2b_extra: res=%b required no result", res_data1);
        end else begin
          e = exp_q.pop_front();
          if (res_data1 !== e) begin
            miscompares++;
            $display("FAIL b2b_result: res=%b required %b", res_data1, e);
          end
        end
      end
      if (in_ready1 && idx < 4) idx++;
      step();
      n++;
    end
    in_valid = 1'b0;
    vectors++;
    if (got != 2 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL b2b_count: results=%0d pending=%0d required 2 0", got, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_settle3();
    logic [3:0] a = 4'($urandom_range(0, 15));
    logic [3:0] b = 4'($urandom_range(0, 15));
    apply_reset();
    res_ready = 1'b1;
    send_beat(a);
    send_beat(b);
    alu_ovr_en = 1'b1;
    alu_ovr    = ~(a ^ b);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (res_valid3 !== 1'b0 || in_ready3 !== 1'b0 || op_a3 !== a || op_b3 !== b) begin
        miscompares++;
        $display("FAIL settle3_wait[%0d]: vld=%b rdy=%b a=%h b=%h required 0 0 %h %h",
                 i, res_valid3, in_ready3, op_a3, op_b3, a, b);
      end
      if (i == 0) alu_ovr = (a ^ b) ^ 4'($urandom_range(1, 15));
      if (i == 1) alu_ovr_en = 1'b0;
      step();
    end
    vectors++;
    if (res_valid3 !== 1'b1 || res_data3 !== (a ^ b)) begin
      miscompares++;
      $display("FAIL settle3_result: vld=%b res=%h required 1 %h", res_valid3, res_data3, a ^ b);
    end
    step();
    vectors++;
    if (res_valid3 !== 1'b0 || in_ready3 !== 1'b1) begin
      miscompares++;
      $display("FAIL settle3_drain: vld=%b rdy=%b required 0 1", res_valid3, in_ready3);
    end
  endtask

  // Reset mid-transaction, then confirm no stray result appears.
  task automatic reset_and_watch(input string tag);
    apply_reset();
    vectors++;
    if ({in_ready1, busy1, res_valid1, res_data1, op_a1, op_b1} !== {1'b1, 1'b0, 1'b0, 12'h000}) begin
      miscompares++;
      $display("FAIL %s_reset: rdy=%b busy=%b vld=%b res=%h a=%h b=%h required 1 0 0 0 0 0",
               tag, in_ready1, busy1, res_valid1, res_data1, op_a1, op_b1);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      vectors++;
      if (res_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
        miscompares++;
        $display("FAIL %s_quiet[%0d]: vld=%b rdy=%b required 0 1", tag, i, res_valid1, in_ready1);
      end
    end
  endtask

  task automatic test_reset_mid();
    res_ready = 1'b1;
    send_beat(4'($urandom_range(1, 15)));
    reset_and_watch("rst_get_b");
    res_ready = 1'b0;
    send_beat(4'($urandom_range(1, 15)));
    send_beat(4'($urandom_range(1, 15)));
    step();
    vectors++;
    if (res_valid1 !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_done_setup: vld=%b required 1", res_valid1);
    end
    res_ready = 1'b1;
    reset_and_watch("rst_done");
  endtask

  task automatic test_exhaustive();
    int stall;
    logic [3:0] e;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        res_ready = 1'b0;
        send_beat(4'(a));
        send_beat(4'(b));
        wait_res1();
        e = 4'(a) ^ 4'(b);
        vectors++;
        if (res_data1 !== e) begin
          miscompares++;
          $display("FAIL exhaustive a=%h b=%h: res=%h required %h", a, b, res_data1, e);
        end
        stall = $urandom_range(0, 2);
        for (int s = 0; s < stall; s++) step();
        res_ready = 1'b1;
        step();
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = 4'h0;
    res_ready  = 1'b0;
    alu_ovr_en = 1'b0;
    alu_ovr    = 4'h0;
    step();
    test_reset();
    test_basic_xor();
    test_backpressure();
    test_back_to_back();
    test_settle3();
    test_reset_mid();
    apply_reset();
    test_exhaustive();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
